// File: rtl/joystick_adc_reader.sv
// MCP3202 SPI master: converts joystick channel 0 then channel 1, forever, and holds each result.
// Define JOY_ADC_FILTER_EN for a 4-sample moving average per channel. With CLK_DIV < 4 the MISO
// synchronizer has no timing margin, so record that wherever such a value is used.
module joystick_adc_reader #(
  parameter int CLK_DIV    = 25,
  parameter int GAP_CYCLES = 25
) (
  input  logic        clk25,
  input  logic        rst,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic [11:0] ch0,
  output logic [11:0] ch1,
  output logic        valid
);
  localparam int          CNT_MAX  = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
  localparam int          CNT_W    = $clog2(CNT_MAX);
  localparam logic [11:0] CENTRE   = 12'd2048;
  localparam logic [4:0]  LAST_BIT = 5'd17;

  typedef enum logic [1:0] {S_GAP, S_SETUP, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic             sel_q, sel_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [11:0]      shreg_q, shreg_d;
  logic             miso_meta_q, miso_sync_q;
  logic             done;
  logic             gap_last, half_last;
  logic [11:0]      ch0_q, ch1_q;
  logic             valid_q;
  logic [11:0]      result0, result1;

  // Command frame: START, SGL, ODD (channel), MSBF, then zeros.
  function automatic logic cmd_bit(input logic [4:0] k, input logic odd);
    case (k)
      5'd1, 5'd2, 5'd4: cmd_bit = 1'b1;
      5'd3:             cmd_bit = odd;
      default:          cmd_bit = 1'b0;
    endcase
  endfunction

  assign gap_last  = (cnt_q == CNT_W'(GAP_CYCLES - 1));
  assign half_last = (cnt_q == CNT_W'(CLK_DIV - 1));

  // NOTE: sequential state uses <= so every flop samples values from before the edge.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q     <= S_GAP;
      cnt_q       <= '0;
      bit_q       <= '0;
      sel_q       <= 1'b1;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      shreg_q     <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sel_q       <= sel_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      shreg_q     <= shreg_d;
      miso_meta_q <= adc_miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first, so no branch can leave a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sel_d   = sel_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    case (state_q)
      S_GAP: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (gap_last) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          sel_d   = ~sel_q;
          cs_n_d  = 1'b0;
          mosi_d  = cmd_bit(5'd1, ~sel_q);
        end
      end
      S_SETUP: begin
        if (half_last) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = 5'd1;
          sclk_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (half_last) begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: present the bit for the next period.
            sclk_d = 1'b0;
            mosi_d = cmd_bit(bit_q + 5'd1, sel_q);
          end else if (bit_q == LAST_BIT) begin
            state_d = S_GAP;
            bit_d   = '0;
            cs_n_d  = 1'b1;
            done    = 1'b1;
          end else begin
            // Rising edge of period bit_q+1; periods 6..17 carry B11..B0.
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
            if (bit_q >= 5'd5) shreg_d = {shreg_q[10:0], miso_sync_q};
          end
        end
      end
      default: begin
        state_d = S_GAP;
        cnt_d   = '0;
        bit_d   = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

`ifdef JOY_ADC_FILTER_EN
  logic [11:0] hist0_q [3];
  logic [11:0] hist1_q [3];
  logic [13:0] sum0, sum1;

  always_comb begin
    sum0    = 14'(shreg_q) + 14'(hist0_q[0]) + 14'(hist0_q[1]) + 14'(hist0_q[2]);
    sum1    = 14'(shreg_q) + 14'(hist1_q[0]) + 14'(hist1_q[1]) + 14'(hist1_q[2]);
    result0 = 12'(sum0 >> 2);
    result1 = 12'(sum1 >> 2);
  end

  // NOTE: the history is only three registers per channel, so it is reset to centre like any flop.
  always_ff @(posedge clk25) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        hist0_q[i] <= CENTRE;
        hist1_q[i] <= CENTRE;
      end
    end else if (done) begin
      if (!sel_q) begin
        hist0_q[0] <= shreg_q;
        hist0_q[1] <= hist0_q[0];
        hist0_q[2] <= hist0_q[1];
      end else begin
        hist1_q[0] <= shreg_q;
        hist1_q[1] <= hist1_q[0];
        hist1_q[2] <= hist1_q[1];
      end
    end
  end
`else
  assign result0 = shreg_q;
  assign result1 = shreg_q;
`endif

  always_ff @(posedge clk25) begin
    if (rst) begin
      ch0_q   <= CENTRE;
      ch1_q   <= CENTRE;
      valid_q <= 1'b0;
    end else begin
      valid_q <= done && sel_q;
      if (done && !sel_q) ch0_q <= result0;
      if (done && sel_q)  ch1_q <= result1;
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign adc_mosi = mosi_q;
  assign ch0      = ch0_q;
  assign ch1      = ch1_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_joystick_adc_reader.sv
// Directed bench for joystick_adc_reader with a behavioural MCP3202 on the SPI pins.
// Builds with or without JOY_ADC_FILTER_EN; expected values follow the build.
module tb_joystick_adc_reader;
  localparam int CLK_DIV = 25;

`ifdef JOY_ADC_FILTER_EN
  localparam logic [11:0] EXP_F1_CH0 = 12'd2223;
  localparam logic [11:0] EXP_F2_CH1 = 12'd1608;
  localparam logic [11:0] EXP_B1_CH0 = 12'd1536;
  localparam logic [11:0] EXP_B1_CH1 = 12'd2559;
  localparam logic [11:0] EXP_B2_CH0 = 12'd2047;
  localparam logic [11:0] EXP_B2_CH1 = 12'd2047;
`else
  localparam logic [11:0] EXP_F1_CH0 = 12'hABC;
  localparam logic [11:0] EXP_F2_CH1 = 12'h123;
  localparam logic [11:0] EXP_B1_CH0 = 12'h000;
  localparam logic [11:0] EXP_B1_CH1 = 12'hFFF;
  localparam logic [11:0] EXP_B2_CH0 = 12'hFFF;
  localparam logic [11:0] EXP_B2_CH1 = 12'h000;
`endif

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        adc_cs_n, adc_sclk, adc_mosi;
  logic        adc_miso = 1'b0;
  logic [11:0] ch0, ch1;
  logic        valid;

  int errors = 0;
  int checks = 0;

  logic [11:0] resp0 = 12'h000;
  logic [11:0] resp1 = 12'h000;

  // Model / monitor state
  int          cyc = 0;
  int          run = 0;
  int          m_bits = 0;
  int          m_phase_bad = 0;
  logic [3:0]  m_cmd = 4'b0000;
  logic [11:0] m_word = 12'h000;
  int          frm_count = 0;
  int          f_bits = 0;
  int          f_phase_bad = 0;
  logic [3:0]  f_cmd = 4'b0000;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic        cs_rise;
  logic [11:0] ch0_prev, ch1_prev;
  int          ch_bad = 0;
  int          valid_bad = 0;
  int          v_cnt = 0;
  int          v_last_t = 0;
  int          v_prev_t = 0;

  joystick_adc_reader #(.CLK_DIV(25), .GAP_CYCLES(25)) dut (
    .clk25    (clk25),
    .rst      (rst),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .adc_mosi (adc_mosi),
    .adc_miso (adc_miso),
    .ch0      (ch0),
    .ch1      (ch1),
    .valid    (valid)
  );

  always #20 clk25 = ~clk25;

  // MCP3202 model: latches DIN on SCLK rise, updates DOUT on SCLK fall (null bit after MSBF).
  always @(negedge clk25) begin
    cyc++;
    cs_rise = !cs_prev && adc_cs_n;
    if (cs_prev && !adc_cs_n) begin
      m_bits = 0;
      m_cmd = 4'b0000;
      m_phase_bad = 0;
      adc_miso = 1'b0;
      run = 1;
    end else if (cs_rise) begin
      if (run != CLK_DIV) m_phase_bad++;
      f_bits = m_bits;
      f_cmd = m_cmd;
      f_phase_bad = m_phase_bad;
      frm_count++;
      adc_miso = 1'b0;
    end else if (!adc_cs_n && adc_sclk !== sclk_prev) begin
      if (adc_sclk) begin
        m_bits++;
        if (m_bits <= 4) m_cmd[4-m_bits] = adc_mosi;
        if (m_bits > 1 && run != CLK_DIV) m_phase_bad++;
      end else begin
        if (run != CLK_DIV) m_phase_bad++;
        if (m_bits == 4) m_word = m_cmd[1] ? resp1 : resp0;
        if (m_bits >= 5 && m_bits <= 16) adc_miso = m_word[16-m_bits];
        else adc_miso = 1'b0;
      end
      run = 1;
    end else begin
      run++;
    end

    if (rst !== 1'b1) begin
      if ((ch0 !== ch0_prev || ch1 !== ch1_prev) && !cs_rise) ch_bad++;
      if (valid === 1'b1 && !(cs_rise && m_cmd[1])) valid_bad++;
    end
    if (valid === 1'b1) begin
      v_cnt++;
      v_prev_t = v_last_t;
      v_last_t = cyc;
    end
    cs_prev = adc_cs_n;
    sclk_prev = adc_sclk;
    ch0_prev = ch0;
    ch1_prev = ch1;
  end

  task automatic tick();
    @(negedge clk25);
    #1;
  endtask

  task automatic wait_frame(output bit timed_out);
    int base;
    base = frm_count;
    timed_out = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (frm_count != base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_cs_fall(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (adc_cs_n === 1'b0) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    resp0 = 12'hABC;
    resp1 = 12'h123;
    repeat (5) tick();
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", adc_sclk); end
    checks++; if (adc_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", adc_mosi); end
    checks++; if (ch0 !== 12'd2048) begin errors++; $display("FAIL reset_ch0: got %0d want 2048", ch0); end
    checks++; if (ch1 !== 12'd2048) begin errors++; $display("FAIL reset_ch1: got %0d want 2048", ch1); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    rst = 1'b0;
    wait_cs_fall(n);
    checks++; if (n != 25) begin errors++; $display("FAIL first_cs_fall: got %0d want 25 cycles", n); end
  endtask

  task automatic test_frame_and_data();
    bit to;
    wait_frame(to);
    checks++; if (to) begin errors++; $display("FAIL frame1_timeout: got timeout want frame end"); end
    checks++; if (f_bits != 17) begin errors++; $display("FAIL frame1_edges: got %0d want 17", f_bits); end
    checks++; if (f_cmd !== 4'b1101) begin errors++; $display("FAIL frame1_cmd: got %b want 1101", f_cmd); end
    checks++; if (f_phase_bad != 0) begin errors++; $display("FAIL frame1_phase: got %0d bad phases want 0", f_phase_bad); end
    checks++; if (ch0 !== EXP_F1_CH0) begin errors++; $display("FAIL frame1_ch0: got %h want %h", ch0, EXP_F1_CH0); end
    checks++; if (ch1 !== 12'd2048) begin errors++; $display("FAIL frame1_ch1_hold: got %0d want 2048", ch1); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL frame1_valid: got %b want 0", valid); end

    wait_frame(to);
    checks++; if (to) begin errors++; $display("FAIL frame2_timeout: got timeout want frame end"); end
    checks++; if (f_bits != 17) begin errors++; $display("FAIL frame2_edges: got %0d want 17", f_bits); end
    checks++; if (f_cmd !== 4'b1111) begin errors++; $display("FAIL frame2_cmd: got %b want 1111", f_cmd); end
    checks++; if (f_phase_bad != 0) begin errors++; $display("FAIL frame2_phase: got %0d bad phases want 0", f_phase_bad); end
    checks++; if (ch1 !== EXP_F2_CH1) begin errors++; $display("FAIL frame2_ch1: got %h want %h", ch1, EXP_F2_CH1); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL frame2_valid: got %b want 1", valid); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b want 0", valid); end

    wait_frame(to);
    wait_frame(to);
    checks++; if (to) begin errors++; $display("FAIL frame4_timeout: got timeout want frame end"); end
    checks++; if (v_last_t - v_prev_t != 1800) begin
      errors++; $display("FAIL pair_period: got %0d want 1800 cycles", v_last_t - v_prev_t);
    end
  endtask

  task automatic test_boundaries();
    bit to;
    int n;
    resp0 = 12'h000;
    resp1 = 12'hFFF;
    apply_reset();
    wait_cs_fall(n);
    wait_frame(to);
    checks++; if (ch0 !== EXP_B1_CH0) begin errors++; $display("FAIL bound_ch0_zero: got %h want %h", ch0, EXP_B1_CH0); end
    wait_frame(to);
    checks++; if (ch1 !== EXP_B1_CH1) begin errors++; $display("FAIL bound_ch1_full: got %h want %h", ch1, EXP_B1_CH1); end
    resp0 = 12'hFFF;
    resp1 = 12'h000;
    wait_frame(to);
    checks++; if (ch0 !== EXP_B2_CH0) begin errors++; $display("FAIL bound_ch0_full: got %h want %h", ch0, EXP_B2_CH0); end
    wait_frame(to);
    checks++; if (to) begin errors++; $display("FAIL bound_timeout: got timeout want frame end"); end
    checks++; if (ch1 !== EXP_B2_CH1) begin errors++; $display("FAIL bound_ch1_zero: got %h want %h", ch1, EXP_B2_CH1); end
  endtask

  task automatic test_reset_mid_shift();
    bit to;
    int n;
    int v_base;
    bit found;
    resp0 = 12'h800;
    resp1 = 12'h800;
    apply_reset();
    wait_cs_fall(n);
    wait_frame(to);
    wait_frame(to);
    resp1 = 12'h555;
    wait_frame(to);
    wait_cs_fall(n);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (m_bits == 9 && adc_sclk === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_edge9: got timeout want SCLK edge 9"); end
    rst = 1'b1;
    v_base = v_cnt;
    tick();
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n: got %b want 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b want 0", adc_sclk); end
    checks++; if (ch1 !== 12'd2048) begin errors++; $display("FAIL mid_ch1: got %h want 800", ch1); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid); end
    tick();
    tick();
    rst = 1'b0;
    checks++; if (v_cnt != v_base) begin errors++; $display("FAIL mid_no_valid: got %0d pulses want 0", v_cnt - v_base); end
    wait_cs_fall(n);
    checks++; if (n != 25) begin errors++; $display("FAIL mid_restart_gap: got %0d want 25 cycles", n); end
    wait_frame(to);
    checks++; if (f_cmd !== 4'b1101) begin errors++; $display("FAIL mid_restart_cmd: got %b want 1101", f_cmd); end
    checks++; if (f_bits != 17) begin errors++; $display("FAIL mid_restart_edges: got %0d want 17", f_bits); end
  endtask

`ifdef JOY_ADC_FILTER_EN
  task automatic test_filter();
    bit to;
    int n;
    logic [11:0] exp_f [4] = '{12'd2536, 12'd3024, 12'd3512, 12'd4000};
    resp0 = 12'd4000;
    resp1 = 12'd0;
    apply_reset();
    wait_cs_fall(n);
    for (int i = 0; i < 4; i++) begin
      wait_frame(to);
      checks++; if (ch0 !== exp_f[i]) begin errors++; $display("FAIL filter_ch0_%0d: got %0d want %0d", i, ch0, exp_f[i]); end
      wait_frame(to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_and_data();
    test_boundaries();
    test_reset_mid_shift();
`ifdef JOY_ADC_FILTER_EN
    test_filter();
`endif
    checks++; if (ch_bad != 0) begin errors++; $display("FAIL ch_stability: got %0d stray updates want 0", ch_bad); end
    checks++; if (valid_bad != 0) begin errors++; $display("FAIL valid_placement: got %0d stray pulses want 0", valid_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got no completion want finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
